// File: rtl/ram_bist_pkg.sv
// Shared types and constants for the RAM built-in self-test block.
package ram_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] PAT_ZERO = 2'd0;
  localparam logic [1:0] PAT_ONES = 2'd1;
  localparam logic [1:0] PAT_CHK  = 2'd2;
  localparam logic [1:0] PAT_SEED = 2'd3;

  localparam logic [31:0] CHK_EVEN = 32'hAAAA_AAAA;
  localparam logic [31:0] CHK_ODD  = 32'h5555_5555;

endpackage

// File: rtl/ram_bist_if.sv
// Control/status and RAM-side signals of the BIST; master is the BIST, slave the environment.
interface ram_bist_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic              start;
  logic [1:0]        pattern_sel;
  logic [DATA_W-1:0] seed;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ADDR_W:0]   err_count;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_data;
  logic              mem_w_en;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_input;
  logic [DATA_W-1:0] mem_data_output;

  modport master (
    input  start, pattern_sel, seed, mem_data_output,
    output busy, done, pass, err_count, fail_addr, fail_data,
           mem_w_en, mem_address, mem_data_input
  );

  modport slave (
    output start, pattern_sel, seed, mem_data_output,
    input  busy, done, pass, err_count, fail_addr, fail_data,
           mem_w_en, mem_address, mem_data_input
  );
endinterface

// File: rtl/ram_bist_patgen.sv
// Expected word for a given address under the latched pattern; shared by write and compare paths.
module ram_bist_patgen
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic [1:0]        i_pattern,
  input  logic [DATA_W-1:0] i_seed,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] o_exp
);

  always_comb begin
    o_exp = '0;
    case (i_pattern)
      PAT_ZERO: o_exp = '0;
      PAT_ONES: o_exp = '1;
      PAT_CHK:  o_exp = i_addr[0] ? DATA_W'(CHK_ODD) : DATA_W'(CHK_EVEN);
      PAT_SEED: o_exp = i_seed + DATA_W'(i_addr);
      default:  o_exp = '0;
    endcase
  end

endmodule

// File: rtl/ram_bist.sv
// RAM BIST initiator: writes a pattern to every word, reads back, and records mismatch results.
module ram_bist
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic      clk,
  input  logic      rst,
  ram_bist_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_pat;
  logic [DATA_W-1:0] r_seed;
  logic [ADDR_W:0]   r_err;
  logic              r_pass;
  logic [ADDR_W-1:0] r_fail_addr;
  logic [DATA_W-1:0] r_fail_data;

  logic [DATA_W-1:0] w_exp;
  logic              w_last;
  logic              w_mismatch;
  logic [ADDR_W:0]   w_err_nxt;

  ram_bist_patgen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_patgen (
    .i_pattern (r_pat),
    .i_seed    (r_seed),
    .i_addr    (r_addr),
    .o_exp     (w_exp)
  );

  assign w_last     = (r_addr == LAST_ADDR);
  assign w_mismatch = (bus.mem_data_output != w_exp);
  assign w_err_nxt  = r_err + (ADDR_W+1)'(w_mismatch);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_pat       <= '0;
      r_seed      <= '0;
      r_err       <= '0;
      r_pass      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_pat       <= bus.pattern_sel;
            r_seed      <= bus.seed;
            r_addr      <= '0;
            r_err       <= '0;
            r_pass      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
          end
        end
        ST_WRITE: r_addr <= w_last ? '0 : r_addr + ADDR_W'(1);
        ST_READ: begin
          r_addr <= w_last ? '0 : r_addr + ADDR_W'(1);
          r_err  <= w_err_nxt;
          if (w_mismatch && (r_err == '0)) begin
            r_fail_addr <= r_addr;
            r_fail_data <= bus.mem_data_output;
          end
          // pass must include the final compare, so it uses the updated count
          if (w_last) r_pass <= (w_err_nxt == '0);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    bus.busy           = 1'b0;
    bus.done           = 1'b0;
    bus.mem_w_en       = 1'b0;
    bus.mem_data_input = '0;
    case (r_state)
      ST_IDLE: if (bus.start) w_state_nxt = ST_WRITE;
      ST_WRITE: begin
        bus.busy           = 1'b1;
        bus.mem_w_en       = 1'b1;
        bus.mem_data_input = w_exp;
        if (w_last) w_state_nxt = ST_READ;
      end
      ST_READ: begin
        bus.busy = 1'b1;
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        bus.busy    = 1'b1;
        bus.done    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.mem_address = r_addr;
  assign bus.pass        = r_pass;
  assign bus.err_count   = r_err;
  assign bus.fail_addr   = r_fail_addr;
  assign bus.fail_data   = r_fail_data;

endmodule

// File: tb/tb_ram_bist.sv
// Self-checking bench for ram_bist: vector table, randomized runs against a reference model, corner sequences.
module tb_ram_bist;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam logic [31:0] NF = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_bist_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_bist #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM model with read-side fault injection (AND/OR masks per word, global OR)
  logic [DW-1:0] ram  [DEPTH];
  logic [DW-1:0] andm [DEPTH];
  logic [DW-1:0] orm  [DEPTH];
  logic [DW-1:0] g_or;

  always @(posedge clk) if (bus.mem_w_en) ram[bus.mem_address] <= bus.mem_data_input;
  assign bus.mem_data_output = (ram[bus.mem_address] & andm[bus.mem_address])
                             | orm[bus.mem_address] | g_or;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_exp(input int pat, input logic [DW-1:0] sd, input int a);
    case (pat)
      0:       return '0;
      1:       return '1;
      2:       return (a % 2 == 0) ? 32'hAAAA_AAAA : 32'h5555_5555;
      default: return sd + DW'(a);
    endcase
  endfunction

  task automatic clear_faults();
    for (int i = 0; i < DEPTH; i++) begin
      andm[i] = NF;
      orm[i]  = '0;
    end
    g_or = '0;
  endtask

  // start sampled at edge E0; returns cycle index (1-based) in which done is seen
  task automatic run(input int pat, input logic [DW-1:0] sd, input int extra_start_cyc,
                     input int chg_cyc, input int chg_pat,
                     output int done_cyc, output int busy_cnt, output bit seq_ok);
    bus.start       = 1'b1;
    bus.pattern_sel = 2'(pat);
    bus.seed        = sd;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.seed  = $urandom();
    done_cyc  = 0;
    busy_cnt  = 0;
    seq_ok    = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      bus.start = (c == extra_start_cyc);
      if (c == chg_cyc) bus.pattern_sel = 2'(chg_pat);
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (c == 1) begin
        chk("start_clears_pass", 64'(bus.pass), 64'(0));
        chk("start_clears_err", 64'(bus.err_count), 64'(0));
      end
      if (c <= 16)
        seq_ok &= (bus.mem_w_en === 1'b1) && (bus.mem_address === AW'(c - 1));
      else if (c <= 32)
        seq_ok &= (bus.mem_w_en === 1'b0) && (bus.mem_address === AW'(c - 17))
                  && (bus.mem_data_input === '0);
      if (bus.done) begin
        done_cyc = c;
        break;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
  endtask

  typedef struct {
    int          pat;
    logic [31:0] seed;
    int          f1w;
    logic [31:0] f1and;
    logic [31:0] f1or;
    int          f2w;
    logic [31:0] f2and;
    logic [31:0] f2or;
    logic [31:0] gor;
    bit          xpass;
    int          xerr;
    int          xfa;
    logic [31:0] xfd;
    logic [31:0] xw0, xw1, xw2, xw15;
  } vec_t;

  vec_t tbl[7];

  task automatic check_run(input string tag, input int done_cyc, input int busy_cnt, input bit seq_ok,
                           input bit xpass, input int xerr, input int xfa, input logic [DW-1:0] xfd);
    chk({tag, "_done_cycle"}, 64'(done_cyc), 64'(33));
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(33));
    chk({tag, "_addr_sequence"}, 64'(seq_ok), 64'(1));
    chk({tag, "_pass"}, 64'(bus.pass), 64'(xpass));
    chk({tag, "_err_count"}, 64'(bus.err_count), 64'(xerr));
    chk({tag, "_fail_addr"}, 64'(bus.fail_addr), 64'(xfa));
    chk({tag, "_fail_data"}, 64'(bus.fail_data), 64'(xfd));
  endtask

  task automatic check_dump(input string tag, input int pat, input logic [DW-1:0] sd);
    int bad;
    bad = 0;
    for (int a = 0; a < DEPTH; a++) if (ram[a] !== model_exp(pat, sd, a)) bad++;
    chk({tag, "_ram_dump_bad_words"}, 64'(bad), 64'(0));
  endtask

  initial begin
    int   dc, bc, xerr, xfa, nf, w, d1, d2, done_seen;
    bit   so, xpass;
    logic [DW-1:0] sd, rd, xfd;
    int   pat;

    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    clear_faults();
    bus.start = 1'b0; bus.pattern_sel = 2'd0; bus.seed = '0;

    //                pat seed      f1w f1and      f1or         f2w f2and      f2or gor xpass xerr xfa xfd           w0            w1            w2            w15
    tbl[0] = '{2, 32'h0,        0, NF,          32'h0,        0, NF,          32'h0, 32'h0, 1, 0,  0,  32'h0,        32'hAAAAAAAA, 32'h55555555, 32'hAAAAAAAA, 32'h55555555};
    tbl[1] = '{3, 32'hFFFFFFFE, 0, NF,          32'h0,        0, NF,          32'h0, 32'h0, 1, 0,  0,  32'h0,        32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h0000000D};
    tbl[2] = '{0, 32'h0,        5, NF,          32'h1,        0, NF,          32'h0, 32'h0, 0, 1,  5,  32'h00000001, 32'h0,        32'h0,        32'h0,        32'h0};
    tbl[3] = '{1, 32'h0,        3, 32'hFFFFFFFE, 32'h0,       9, 32'hFFFFFFFE, 32'h0, 32'h0, 0, 2,  3,  32'hFFFFFFFE, NF,           NF,           NF,           NF};
    tbl[4] = '{3, 32'h100,      15, NF,         32'h80000000, 0, NF,          32'h0, 32'h0, 0, 1,  15, 32'h8000010F, 32'h100,      32'h101,      32'h102,      32'h10F};
    tbl[5] = '{1, 32'h0,        0, 32'h0,       32'h0,        0, NF,          32'h0, 32'h0, 0, 1,  0,  32'h0,        NF,           NF,           NF,           NF};
    tbl[6] = '{0, 32'h0,        0, NF,          32'h0,        0, NF,          32'h0, 32'h1, 0, 16, 0,  32'h00000001, 32'h0,        32'h0,        32'h0,        32'h0};

    // reset, and the "not run" state immediately after it
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_pass", 64'(bus.pass), 64'(0));
    chk("rst_err_count", 64'(bus.err_count), 64'(0));
    chk("rst_fail_addr", 64'(bus.fail_addr), 64'(0));
    chk("rst_fail_data", 64'(bus.fail_data), 64'(0));
    chk("rst_mem_w_en", 64'(bus.mem_w_en), 64'(0));
    chk("rst_mem_address", 64'(bus.mem_address), 64'(0));
    chk("rst_mem_data_input", 64'(bus.mem_data_input), 64'(0));
    @(posedge clk); #1;

    // table-driven runs
    for (int t = 0; t < 7; t++) begin
      clear_faults();
      andm[tbl[t].f1w] &= tbl[t].f1and;
      orm[tbl[t].f1w]  |= tbl[t].f1or;
      andm[tbl[t].f2w] &= tbl[t].f2and;
      orm[tbl[t].f2w]  |= tbl[t].f2or;
      g_or = tbl[t].gor;
      run(tbl[t].pat, tbl[t].seed, 0, 0, 0, dc, bc, so);
      check_run($sformatf("tbl%0d", t), dc, bc, so, tbl[t].xpass, tbl[t].xerr, tbl[t].xfa, tbl[t].xfd);
      chk($sformatf("tbl%0d_word0", t), 64'(ram[0]), 64'(tbl[t].xw0));
      chk($sformatf("tbl%0d_word1", t), 64'(ram[1]), 64'(tbl[t].xw1));
      chk($sformatf("tbl%0d_word2", t), 64'(ram[2]), 64'(tbl[t].xw2));
      chk($sformatf("tbl%0d_word15", t), 64'(ram[15]), 64'(tbl[t].xw15));
      @(posedge clk); #1;
      if (t == 0) begin
        repeat (2) @(posedge clk);
        #1;
        chk("hold_busy", 64'(bus.busy), 64'(0));
        chk("hold_pass", 64'(bus.pass), 64'(1));
        chk("hold_err_count", 64'(bus.err_count), 64'(0));
      end
    end

    // randomized runs against the reference model
    for (int r = 0; r < 10; r++) begin
      clear_faults();
      pat = $urandom_range(0, 3);
      sd  = $urandom();
      nf  = $urandom_range(0, 3);
      for (int k = 0; k < nf; k++) begin
        w = $urandom_range(0, DEPTH - 1);
        orm[w]  |= $urandom() & $urandom();
        andm[w] &= ~($urandom() & $urandom());
      end
      xerr = 0; xfa = 0; xfd = '0;
      for (int a = 0; a < DEPTH; a++) begin
        rd = (model_exp(pat, sd, a) & andm[a]) | orm[a] | g_or;
        if (rd != model_exp(pat, sd, a)) begin
          if (xerr == 0) begin xfa = a; xfd = rd; end
          xerr++;
        end
      end
      xpass = (xerr == 0);
      run(pat, sd, 0, 0, 0, dc, bc, so);
      check_run($sformatf("rnd%0d", r), dc, bc, so, xpass, xerr, xfa, xfd);
      check_dump($sformatf("rnd%0d", r), pat, sd);
      @(posedge clk); #1;
    end

    // start pulsed during READ is ignored
    clear_faults();
    run(2, 32'h0, 20, 0, 0, dc, bc, so);
    check_run("restart_in_read", dc, bc, so, 1'b1, 0, 0, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("restart_in_read_idle_after", 64'(bus.busy), 64'(0));
    @(posedge clk); #1;

    // pattern_sel changes mid-WRITE have no effect
    run(1, 32'h0, 0, 5, 0, dc, bc, so);
    check_run("pat_change", dc, bc, so, 1'b1, 0, 0, 32'h0);
    check_dump("pat_change", 1, 32'h0);
    @(posedge clk); #1;

    // rst asserted in WRITE cycle 7
    bus.start = 1'b1; bus.pattern_sel = 2'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_in_write", 64'(bus.mem_w_en), 64'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_mem_w_en", 64'(bus.mem_w_en), 64'(0));
    chk("abort_busy", 64'(bus.busy), 64'(0));
    chk("abort_err_count", 64'(bus.err_count), 64'(0));
    chk("abort_mem_address", 64'(bus.mem_address), 64'(0));
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_seen++;
    end
    chk("abort_no_done", 64'(done_seen), 64'(0));
    @(posedge clk); #1;

    // start held high: back-to-back tests, second done 34 cycles after the first
    bus.start = 1'b1; bus.pattern_sel = 2'd0;
    @(posedge clk); #1;
    d1 = 0; d2 = 0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (bus.done) begin
        if (d1 == 0) d1 = c;
        else if (d2 == 0) d2 = c;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    chk("held_start_first_done", 64'(d1), 64'(33));
    chk("held_start_second_done", 64'(d2), 64'(67));
    for (int c = 0; c < 50 && bus.busy; c++) begin
      @(posedge clk); #1;
    end
    chk("held_start_returns_idle", 64'(bus.busy), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
